// File: rtl/fetch_unit.sv
// Instruction fetch stage: one-outstanding ibus fetch feeding the fetch/decode register.
// Latency: an instruction reaches decode on the edge its data_ok is seen, or the first unstalled edge after that.
// Backpressure: stall holds the decode register; a fetch that completes while stalled parks in a one-entry buffer.
module fetch_unit (
    input  logic        clk_i,
    input  logic        resetn_i,
    input  logic        stall_i,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i,
    output logic        ireq_valid_o,
    output logic [31:0] ireq_addr_o,
    input  logic        iresp_addr_ok_i,
    input  logic        iresp_data_ok_i,
    input  logic [31:0] iresp_data_i,
    output logic [31:0] instr_d_o,
    output logic [31:0] pc_d_o,
    output logic        valid_d_o
);

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        ireq_valid_q, ireq_valid_d;
    logic        redir_pend_q, redir_pend_d;
    logic [31:0] redir_tgt_q, redir_tgt_d;
    logic [31:0] hold_buf_q, hold_buf_d;
    logic [31:0] dec_instr_q, dec_instr_d;
    logic [31:0] dec_pc_q, dec_pc_d;
    logic        dec_vld_q, dec_vld_d;

    logic        fetch_done;
    logic        deliver;
    logic [31:0] next_pc;

    // A fetch finishes on data_ok; in REQ the address must also be accepted in the same cycle.
    // An instruction is delivered from the bus or the hold buffer whenever decode is not stalled.
    always_comb begin
        fetch_done = ((state_q == ST_REQ) && iresp_addr_ok_i && iresp_data_ok_i) ||
                     ((state_q == ST_WAIT) && iresp_data_ok_i);
        deliver    = !stall_i && (fetch_done || (state_q == ST_HOLD));
        if (redirect_valid_i) begin
            next_pc = redirect_pc_i;
        end else if (redir_pend_q) begin
            next_pc = redir_tgt_q;
        end else begin
            next_pc = pc_q + 32'd4;
        end
    end

    // Next-state for the FSM, fetch PC, redirect tracking, hold buffer and decode register.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        redir_pend_d = redir_pend_q;
        redir_tgt_d  = redir_tgt_q;
        hold_buf_d   = hold_buf_q;
        dec_instr_d  = dec_instr_q;
        dec_pc_d     = dec_pc_q;
        dec_vld_d    = dec_vld_q;

        case (state_q)
            ST_IDLE: state_d = ST_REQ;
            ST_REQ: begin
                if (iresp_addr_ok_i) begin
                    if (iresp_data_ok_i) begin
                        state_d = stall_i ? ST_HOLD : ST_REQ;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (iresp_data_ok_i) begin
                    state_d = stall_i ? ST_HOLD : ST_REQ;
                end
            end
            ST_HOLD: begin
                if (!stall_i) begin
                    state_d = ST_REQ;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Completed fetch that decode cannot take yet; pc still names it.
        if (fetch_done && stall_i) begin
            hold_buf_d = iresp_data_i;
        end

        if (deliver) begin
            dec_instr_d  = (state_q == ST_HOLD) ? hold_buf_q : iresp_data_i;
            dec_pc_d     = pc_q;
            dec_vld_d    = 1'b1;
            pc_d         = next_pc;
            redir_pend_d = 1'b0;
        end else begin
            if (!stall_i) begin
                dec_vld_d = 1'b0;
            end
            // Delay slot still in flight: remember where to go after it.
            if (redirect_valid_i) begin
                redir_pend_d = 1'b1;
                redir_tgt_d  = redirect_pc_i;
            end
        end

        ireq_valid_d = (state_d == ST_REQ) || (state_d == ST_WAIT);
    end

    // Single state register block; reset abandons any in-flight fetch.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_PC;
            ireq_valid_q <= 1'b0;
            redir_pend_q <= 1'b0;
            redir_tgt_q  <= 32'd0;
            hold_buf_q   <= 32'd0;
            dec_instr_q  <= 32'd0;
            dec_pc_q     <= 32'd0;
            dec_vld_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ireq_valid_q <= ireq_valid_d;
            redir_pend_q <= redir_pend_d;
            redir_tgt_q  <= redir_tgt_d;
            hold_buf_q   <= hold_buf_d;
            dec_instr_q  <= dec_instr_d;
            dec_pc_q     <= dec_pc_d;
            dec_vld_q    <= dec_vld_d;
        end
    end

    assign ireq_valid_o = ireq_valid_q;
    assign ireq_addr_o  = pc_q;
    assign instr_d_o    = dec_instr_q;
    assign pc_d_o       = dec_pc_q;
    assign valid_d_o    = dec_vld_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with scoreboard queues for bus requests and decode deliveries.
// Stimulus is driven 1 time unit after the rising edge; monitors sample on the falling edge.
// The instruction memory returns a fixed scramble of the request address.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        resetn;
    logic        stall;
    logic        redir;
    logic [31:0] redir_pc;
    logic        ireq_valid;
    logic [31:0] ireq_addr;
    logic        aok;
    logic        dok;
    logic [31:0] rdata;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic        valid_d;

    int tests = 0;
    int fails = 0;

    logic [31:0] exp_addr_q[$];
    logic [63:0] exp_dlv_q[$];

    always #5 clk = ~clk;

    function automatic logic [31:0] fdata(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hA5A5_0F0F;
    endfunction

    assign rdata = fdata(ireq_addr);

    fetch_unit dut (
        .clk_i           (clk),
        .resetn_i        (resetn),
        .stall_i         (stall),
        .redirect_valid_i(redir),
        .redirect_pc_i   (redir_pc),
        .ireq_valid_o    (ireq_valid),
        .ireq_addr_o     (ireq_addr),
        .iresp_addr_ok_i (aok),
        .iresp_data_ok_i (dok),
        .iresp_data_i    (rdata),
        .instr_d_o       (instr_d),
        .pc_d_o          (pc_d),
        .valid_d_o       (valid_d)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_fetch(input logic [31:0] a);
        exp_addr_q.push_back(a);
        exp_dlv_q.push_back({a, fdata(a)});
    endtask

    // Conditions at each rising edge, seen later by the falling-edge monitor.
    logic stall_e = 1'b1;
    logic rst_e   = 1'b0;
    always @(posedge clk) begin
        stall_e <= stall;
        rst_e   <= resetn;
    end

    // Monitor: decode-register loads and completing bus requests against the queues.
    initial begin
        logic        acc;
        logic [63:0] d;
        logic [31:0] a;
        acc = 1'b0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                acc = 1'b0;
            end else begin
                // With stall low the decode valid only rises on a delivery.
                if (rst_e && !stall_e && valid_d) begin
                    if (exp_dlv_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL dlv_unexpected: got pc %h instr %h, expected none", pc_d, instr_d);
                    end else begin
                        d = exp_dlv_q.pop_front();
                        chk("dlv_pc", pc_d, d[63:32]);
                        chk("dlv_instr", instr_d, d[31:0]);
                    end
                end
                if (ireq_valid && dok && (aok || acc)) begin
                    if (exp_addr_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL req_unexpected: got addr %h, expected none", ireq_addr);
                    end else begin
                        a = exp_addr_q.pop_front();
                        chk("req_addr", ireq_addr, a);
                    end
                    acc = 1'b0;
                end else if (ireq_valid && aok && !dok) begin
                    acc = 1'b1;
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn   = 1'b0;
        stall    = 1'b0;
        redir    = 1'b0;
        redir_pc = 32'd0;
        aok      = 1'b0;
        dok      = 1'b0;
        repeat (3) step();

        chk("rst_ireq_vld", {31'd0, ireq_valid}, 32'd0);
        chk("rst_addr", ireq_addr, 32'hBFC0_0000);
        chk("rst_valid_d", {31'd0, valid_d}, 32'd0);
        chk("rst_instr_d", instr_d, 32'd0);
        chk("rst_pc_d", pc_d, 32'd0);

        // Streaming fetch with zero-wait bus.
        resetn = 1'b1;
        aok    = 1'b1;
        dok    = 1'b1;
        chk("idle_vld", {31'd0, ireq_valid}, 32'd0);
        for (int i = 0; i < 4; i++) expect_fetch(32'hBFC0_0000 + 32'(i * 4));
        step();
        chk("first_req_vld", {31'd0, ireq_valid}, 32'd1);
        chk("first_req_addr", ireq_addr, 32'hBFC0_0000);
        chk("first_valid_d", {31'd0, valid_d}, 32'd0);
        repeat (4) step();

        // Accepted fetch with late data and a multi-cycle redirect during the wait.
        aok = 1'b1;
        dok = 1'b0;
        chk("wait_addr", ireq_addr, 32'hBFC0_0010);
        expect_fetch(32'hBFC0_0010);
        step();
        aok      = 1'b0;
        redir    = 1'b1;
        redir_pc = 32'h8000_0100;
        chk("bubble_valid_d", {31'd0, valid_d}, 32'd0);
        for (int c = 0; c < 2; c++) begin
            chk("wait_vld", {31'd0, ireq_valid}, 32'd1);
            chk("wait_addr_stable", ireq_addr, 32'hBFC0_0010);
            step();
        end
        redir = 1'b0;
        dok   = 1'b1;
        chk("wait_addr_last", ireq_addr, 32'hBFC0_0010);
        step();
        dok = 1'b0;
        chk("redir_addr", ireq_addr, 32'h8000_0100);
        chk("redir_vld", {31'd0, ireq_valid}, 32'd1);

        // Fetch completes under stall: parks in the hold buffer.
        stall = 1'b1;
        aok   = 1'b1;
        dok   = 1'b1;
        expect_fetch(32'h8000_0100);
        step();
        aok = 1'b0;
        dok = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("hold_ireq_vld", {31'd0, ireq_valid}, 32'd0);
            chk("hold_valid_d", {31'd0, valid_d}, 32'd1);
            chk("hold_instr_d", instr_d, fdata(32'hBFC0_0010));
            chk("hold_pc_d", pc_d, 32'hBFC0_0010);
            if (c == 2) stall = 1'b0;
            step();
        end
        chk("unhold_instr_d", instr_d, fdata(32'h8000_0100));
        chk("unhold_vld", {31'd0, ireq_valid}, 32'd1);
        chk("unhold_addr", ireq_addr, 32'h8000_0104);

        // Redirect coincident with delivery: no pending target left behind.
        aok      = 1'b1;
        dok      = 1'b1;
        redir    = 1'b1;
        redir_pc = 32'h0000_0040;
        expect_fetch(32'h8000_0104);
        expect_fetch(32'h0000_0040);
        expect_fetch(32'h0000_0044);
        step();
        redir = 1'b0;
        chk("coinc_addr", ireq_addr, 32'h0000_0040);
        step();
        step();
        chk("no_pend_addr", ireq_addr, 32'h0000_0048);

        // PC increment wraps at the top of the address space.
        redir    = 1'b1;
        redir_pc = 32'hFFFF_FFFC;
        expect_fetch(32'h0000_0048);
        expect_fetch(32'hFFFF_FFFC);
        step();
        redir = 1'b0;
        chk("top_addr", ireq_addr, 32'hFFFF_FFFC);
        step();
        aok = 1'b1;
        dok = 1'b0;
        chk("wrap_addr", ireq_addr, 32'h0000_0000);

        // Reset in WAIT abandons the fetch.
        step();
        aok = 1'b0;
        chk("pre_rst_wait_vld", {31'd0, ireq_valid}, 32'd1);
        #1 resetn = 1'b0;
        #1;
        chk("midrst_ireq_vld", {31'd0, ireq_valid}, 32'd0);
        chk("midrst_valid_d", {31'd0, valid_d}, 32'd0);
        chk("midrst_instr_d", instr_d, 32'd0);
        chk("midrst_pc_d", pc_d, 32'd0);
        chk("midrst_addr", ireq_addr, 32'hBFC0_0000);
        step();
        step();
        resetn = 1'b1;
        aok    = 1'b1;
        dok    = 1'b1;
        chk("post_rst_idle_vld", {31'd0, ireq_valid}, 32'd0);
        expect_fetch(32'hBFC0_0000);
        step();
        chk("post_rst_addr", ireq_addr, 32'hBFC0_0000);
        chk("post_rst_vld", {31'd0, ireq_valid}, 32'd1);
        step();
        aok = 1'b0;
        dok = 1'b0;
        chk("post_rst_pc_d", pc_d, 32'hBFC0_0000);
        chk("post_rst_valid_d", {31'd0, valid_d}, 32'd1);
        step();
        step();

        chk("addr_q_drained", 32'(exp_addr_q.size()), 32'd0);
        chk("dlv_q_drained", 32'(exp_dlv_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
